// File: rtl/rw_arb_pkg.sv
// Shared types and default constants for the read/write command-path arbiter.
package rw_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_GNT_RD = 2'd1,
    ST_GNT_WR = 2'd2,
    ST_TURN   = 2'd3
  } state_t;

  localparam int GAP_CYC_DEF       = 2;
  localparam int MAX_GRANT_CYC_DEF = 256;
  localparam int GAP_W             = 4;
  localparam int WD_W              = 16;

endpackage

// File: rtl/rw_arbiter.sv
// Read/write arbiter for a shared memory command path with round-robin, turnaround gap
// and refresh blocking. Optional grant watchdog enabled by defining RW_ARB_WATCHDOG_EN.
module rw_arbiter
  import rw_arb_pkg::*;
#(
  parameter int MAX_GRANT_CYC = MAX_GRANT_CYC_DEF,
  parameter int GAP_CYC       = GAP_CYC_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic req_r,
  input  logic req_w,
  input  logic done_r,
  input  logic done_w,
  input  logic ar_req,
  output logic gnt_r,
  output logic gnt_w,
  output logic busy,
  output logic timeout
);

  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_CYC - 1);

  state_t           state, next_state;
  logic [GAP_W-1:0] gap_cnt;
  logic             last_w;
  logic             armed;
  logic             wd_limit;
  logic             gnt_r_d, gnt_w_d, busy_d;

  // armed blocks grants on the first edge after reset release.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      gap_cnt <= '0;
      last_w  <= 1'b1;
      armed   <= 1'b0;
      gnt_r   <= 1'b0;
      gnt_w   <= 1'b0;
      busy    <= 1'b0;
    end else begin
      state <= next_state;
      armed <= 1'b1;
      gnt_r <= gnt_r_d;
      gnt_w <= gnt_w_d;
      busy  <= busy_d;
      if (state != ST_TURN && next_state == ST_TURN)
        gap_cnt <= GAP_LOAD;
      else if (state == ST_TURN && gap_cnt != '0)
        gap_cnt <= gap_cnt - 1'b1;
      if (state == ST_IDLE && next_state == ST_GNT_RD) last_w <= 1'b0;
      if (state == ST_IDLE && next_state == ST_GNT_WR) last_w <= 1'b1;
    end
  end

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    next_state = state;
    unique case (state)
      ST_IDLE: begin
        if (armed && !ar_req) begin
          if (req_r && (!req_w || last_w)) next_state = ST_GNT_RD;
          else if (req_w)                  next_state = ST_GNT_WR;
        end
      end
      ST_GNT_RD: if (done_r || wd_limit) next_state = ST_TURN;
      ST_GNT_WR: if (done_w || wd_limit) next_state = ST_TURN;
      ST_TURN:   if (gap_cnt == '0)      next_state = ST_IDLE;
      default:   next_state = ST_IDLE;
    endcase
  end

  // Outputs are decoded from the next state and registered, so they never glitch.
  always_comb begin
    gnt_r_d = (next_state == ST_GNT_RD);
    gnt_w_d = (next_state == ST_GNT_WR);
    busy_d  = (next_state != ST_IDLE);
  end

`ifdef RW_ARB_WATCHDOG_EN
  logic [WD_W-1:0] wd_cnt;
  logic            owner_done;

  assign wd_limit   = (wd_cnt == WD_W'(MAX_GRANT_CYC - 1));
  assign owner_done = (state == ST_GNT_RD) ? done_r : done_w;

  // A DONE coinciding with the limit is a normal release, hence the owner_done mask.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_cnt  <= '0;
      timeout <= 1'b0;
    end else begin
      if (state == ST_IDLE)
        wd_cnt <= '0;
      else if (state == ST_GNT_RD || state == ST_GNT_WR)
        wd_cnt <= wd_cnt + 1'b1;
      timeout <= (state == ST_GNT_RD || state == ST_GNT_WR) && wd_limit && !owner_done;
    end
  end
`else
  assign wd_limit = 1'b0;
  assign timeout  = 1'b0;
`endif

endmodule

// File: tb/tb_rw_arbiter.sv
// Self-checking bench for rw_arbiter: directed scenarios plus randomized traffic,
// compared cycle by cycle against a counter-based behavioural model.
module tb_rw_arbiter;

  localparam int GAP   = 2;
  localparam int MAXG  = 8;

  logic clk = 1'b0;
  logic rst_n;
  logic req_r, req_w, done_r, done_w, ar_req;
  logic gnt_r, gnt_w, busy, timeout;

  int n_cmp = 0;
  int n_err = 0;

  // Model: who owns the path, how many grant/turn cycles have elapsed.
  int m_owner;      // 0 none, 1 read, 2 write
  int m_turn_left;  // remaining turnaround cycles, 0 when not turning
  int m_held;       // granted cycles elapsed in current grant
  bit m_last_w;
  bit m_armed;
  bit m_tmo;

  rw_arbiter #(.MAX_GRANT_CYC(MAXG), .GAP_CYC(GAP)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_r(req_r), .req_w(req_w), .done_r(done_r), .done_w(done_w), .ar_req(ar_req),
    .gnt_r(gnt_r), .gnt_w(gnt_w), .busy(busy), .timeout(timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic got, input logic exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %b expected %b", tag, $time, got, exp);
    end
  endtask

  function automatic void model_reset();
    m_owner = 0; m_turn_left = 0; m_held = 0;
    m_last_w = 1'b1; m_armed = 1'b0; m_tmo = 1'b0;
  endfunction

  function automatic void model_step(input bit r, input bit w, input bit dr, input bit dw, input bit ar);
    bit wd_en = 1'b0;
`ifdef RW_ARB_WATCHDOG_EN
    wd_en = 1'b1;
`endif
    m_tmo = 1'b0;
    if (m_turn_left > 0) begin
      m_turn_left--;
    end else if (m_owner == 0) begin
      if (m_armed && !ar && (r || w)) begin
        if (r && w) m_owner = m_last_w ? 1 : 2;
        else        m_owner = r ? 1 : 2;
        m_last_w = (m_owner == 2);
        m_held = 1;
      end
    end else begin
      if ((m_owner == 1 && dr) || (m_owner == 2 && dw)) begin
        m_owner = 0; m_turn_left = GAP;
      end else if (wd_en && m_held == MAXG) begin
        m_owner = 0; m_turn_left = GAP; m_tmo = 1'b1;
      end else begin
        m_held++;
      end
    end
    m_armed = 1'b1;
  endfunction

  task automatic cycle(input bit r, input bit w, input bit dr, input bit dw, input bit ar);
    @(negedge clk);
    check("gnt_r",   gnt_r,   m_owner == 1);
    check("gnt_w",   gnt_w,   m_owner == 2);
    check("busy",    busy,    m_owner != 0 || m_turn_left > 0);
    check("timeout", timeout, m_tmo);
    req_r = r; req_w = w; done_r = dr; done_w = dw; ar_req = ar;
    model_step(r, w, dr, dw, ar);
  endtask

  // Asserts reset shortly after a rising edge and checks outputs drop without a clock.
  task automatic pulse_reset();
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    req_r = 0; req_w = 0; done_r = 0; done_w = 0; ar_req = 0;
    #1;
    check("rst_gnt_r",   gnt_r,   1'b0);
    check("rst_gnt_w",   gnt_w,   1'b0);
    check("rst_busy",    busy,    1'b0);
    check("rst_timeout", timeout, 1'b0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    model_step(0, 0, 0, 0, 0);
  endtask

  task automatic repeat_cycle(input int n, input bit r, input bit w, input bit dr, input bit dw, input bit ar);
    for (int i = 0; i < n; i++) cycle(r, w, dr, dw, ar);
  endtask

  initial begin
    rst_n = 1'b1;
    req_r = 0; req_w = 0; done_r = 0; done_w = 0; ar_req = 0;
    model_reset();
    #2 rst_n = 1'b0;
    #1;
    check("por_gnt_r", gnt_r, 1'b0);
    check("por_busy",  busy,  1'b0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_step(0, 0, 0, 0, 0);

    // Requests right after reset release must not grant on the first edge.
    repeat_cycle(3, 1, 0, 0, 0, 0);
    cycle(0, 0, 1, 0, 0);
    repeat_cycle(4, 0, 0, 0, 0, 0);

    // Single read grant, done on the 5th granted cycle, then turnaround.
    cycle(1, 0, 0, 0, 0);
    repeat_cycle(3, 0, 0, 0, 0, 0);
    cycle(0, 0, 1, 0, 0);
    repeat_cycle(4, 0, 0, 0, 0, 0);

    // Both requesting with dones high: grants alternate.
    repeat_cycle(16, 1, 1, 1, 1, 0);
    repeat_cycle(4, 0, 0, 0, 0, 0);

    // Refresh pending blocks the write request until it drops.
    repeat_cycle(10, 0, 1, 0, 0, 1);
    repeat_cycle(3, 0, 1, 0, 0, 0);
    cycle(0, 0, 0, 1, 0);
    repeat_cycle(4, 0, 0, 0, 0, 0);

    // Write grant with no DONE, then DONE exactly on granted cycle 8.
    cycle(0, 1, 0, 0, 0);
    repeat_cycle(12, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 1, 0);
    repeat_cycle(4, 0, 0, 0, 0, 0);
    cycle(0, 1, 0, 0, 0);
    repeat_cycle(7, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 1, 0);
    repeat_cycle(4, 0, 0, 0, 0, 0);

    // Non-owner DONE, refresh and dropped request during a read grant.
    cycle(1, 0, 0, 0, 0);
    cycle(0, 1, 0, 1, 1);
    cycle(0, 1, 0, 1, 0);
    repeat_cycle(3, 0, 1, 0, 0, 0);
    cycle(0, 0, 1, 0, 0);
    repeat_cycle(4, 0, 0, 0, 0, 0);

    // Reset mid write grant, then simultaneous requests grant read first.
    cycle(0, 1, 0, 0, 0);
    cycle(0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0);
    pulse_reset();
    repeat_cycle(3, 1, 1, 0, 0, 0);
    cycle(0, 0, 1, 1, 0);
    repeat_cycle(6, 1, 1, 0, 0, 0);
    cycle(0, 0, 1, 1, 0);
    repeat_cycle(4, 0, 0, 0, 0, 0);

    // Randomized traffic with occasional reset.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(399) == 0) pulse_reset();
      cycle($urandom_range(2) != 0, $urandom_range(2) != 0,
            $urandom_range(5) == 0, $urandom_range(5) == 0,
            $urandom_range(6) == 0);
    end
    cycle(0, 0, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/rw_arbiter.md
RW_ARBITER -- requirements
Module: rw_arbiter

Interface
REQ-001 Parameter MAX_GRANT_CYC, 256, watchdog limit in cycles per grant (2..65535).
REQ-002 Parameter GAP_CYC, 2, idle turnaround cycles between grants (1..15).
REQ-003 CLK  in  1  single clock; all state changes on the rising edge.
REQ-004 RST_N  in  1  reset, asynchronous, active-low.
REQ-005 REQ_R  in  1  read requester wants the memory command path.
REQ-006 REQ_W  in  1  write requester wants the memory command path.
REQ-007 DONE_R  in  1  read requester's burst-done; ends a read grant.
REQ-008 DONE_W  in  1  write requester's burst-done; ends a write grant.
REQ-009 AR_REQ  in  1  controller auto-refresh pending; blocks new grants.
REQ-010 GNT_R  out  1  read owns the path; drives the selector read-select input.
REQ-011 GNT_W  out  1  write owns the path; drives the selector write-select input.
REQ-012 BUSY  out  1  high in every state except IDLE.
REQ-013 TIMEOUT  out  1  one-cycle pulse when the watchdog forces a release.

Function
REQ-014 The arbiter SHALL use four states: IDLE, GNT_RD, GNT_WR and TURN.
REQ-015 GNT_R and GNT_W SHALL be registered, SHALL never be high together, and SHALL be high only in GNT_RD and GNT_WR respectively.
REQ-016 In IDLE with AR_REQ low, a request sampled at edge k SHALL give the matching grant high after edge k (one-cycle latency).
REQ-017 In IDLE, AR_REQ high SHALL hold the arbiter in IDLE regardless of requests.
REQ-018 If REQ_R and REQ_W are sampled high together in IDLE, the side not granted last SHALL win (round-robin); the last-granted flag resets to "write", so read wins first.
REQ-019 A single pending request SHALL be granted regardless of the last-granted flag.
REQ-020 A grant SHALL be held until the owner's DONE is sampled high; the state SHALL move to TURN after that edge.
REQ-021 While granted, deasserting REQ_x SHALL NOT release the grant.
REQ-022 The non-owner's DONE_x and any AR_REQ during a grant SHALL be ignored (no preemption).
REQ-023 TURN SHALL last exactly GAP_CYC cycles with both grants low; it SHALL then enter IDLE, which may re-grant on the next edge.
REQ-024 The gap counter SHALL be 4 bits; it loads GAP_CYC-1 on entry to TURN and exits TURN at 0.
REQ-025 The last-granted flag SHALL update on entry to GNT_RD or GNT_WR.

Reset
REQ-026 RST_N low SHALL immediately force IDLE, GNT_R=0, GNT_W=0, BUSY=0 and TIMEOUT=0, SHALL set the last-granted flag to write, and SHALL clear all counters, including when it arrives mid-grant or mid-TURN.
REQ-027 After RST_N deasserts, the first grant SHALL occur no earlier than the second rising edge.

Configuration
REQ-028 With RW_ARB_WATCHDOG_EN defined, a 16-bit counter SHALL clear on grant entry and increment each granted cycle.
REQ-029 Under RW_ARB_WATCHDOG_EN, when the counter reaches MAX_GRANT_CYC-1 without DONE, the arbiter SHALL go to TURN and pulse TIMEOUT for one cycle.
REQ-030 Under RW_ARB_WATCHDOG_EN, if DONE and the watchdog limit coincide, the release SHALL be treated as normal, with no TIMEOUT pulse.
REQ-031 Without RW_ARB_WATCHDOG_EN, there SHALL be no watchdog counter, TIMEOUT SHALL be tied 0, and grants SHALL be unbounded.

Structure
REQ-032 The package rw_arb_pkg SHALL hold the state enumeration and the default constants for GAP_CYC and MAX_GRANT_CYC.
REQ-033 rw_arbiter SHALL have no sub-module; the state register, gap counter, watchdog counter and last-granted flag SHALL be local to it.

Verification
REQ-034 Scenario: REQ_R=1 in IDLE at edge 1 -> GNT_R=1 after edge 1; DONE_R=1 at edge 5 -> GNT_R=0 after edge 5; both grants low for 2 cycles; BUSY=1 from edge 1 to the end of TURN.
REQ-035 Scenario: REQ_R and REQ_W held high continuously with GAP_CYC=2 -> grants alternate R,W,R,W, each separated by exactly 2 idle cycles.
REQ-036 Scenario: AR_REQ=1 with REQ_W=1 for 10 cycles -> no grant; AR_REQ=0 at edge 11 -> GNT_W=1 after edge 11.
REQ-037 Scenario: with RW_ARB_WATCHDOG_EN and MAX_GRANT_CYC=8, write granted and DONE_W never asserted -> grant drops after 8 granted cycles and TIMEOUT pulses once; with DONE_W on cycle 8 -> no TIMEOUT.
REQ-038 Scenario: RST_N pulled low on the 3rd cycle of GNT_WR -> GNT_W=0 asynchronously; after release, simultaneous REQ_R and REQ_W grant read first.
REQ-039 Scenario: DONE_W pulsed during GNT_RD and REQ_R dropped while DONE_R=0 -> GNT_R stays high; GNT_W never rises.
